branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic direction predictor for the 5-stage MIPS pipeline.
- In IF, it predicts branches from a table of 2-bit saturating counters indexed by PC.
- The prediction travels with the instruction into ID. There it is checked against the resolved direction from the ID-stage branch comparator (its y output), and the counter is trained.
- Raises mispredictD so hazard/PC-select logic redirects fetch.

Parameters:
- BHT_BITS, 6, log2 of table entries (64 counters); index = pcF[BHT_BITS+1:2].
- PC_W, 32, PC width.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- stallF  input  1  IF stage stalled.
- stallD  input  1  ID stage stalled; IF->ID register holds.
- flushD  input  1  clear IF->ID register (takes priority over stallD).
- pcF  input  PC_W  PC of the instruction in IF.
- branchF  input  1  predecode: IF instruction is a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM).
- predict_takenF  output  1  combinational prediction for the IF instruction.
- branchD  input  1  ID instruction is a conditional branch (from the main decoder).
- actual_takenD  input  1  resolved direction from the ID comparator.
- predict_takenD  output  1  registered prediction carried into ID.
- mispredictD  output  1  branchD & (predict_takenD != actual_takenD).
- branch_cnt  output  32  resolved-branch count (see Optional Feature).
- mispredict_cnt  output  32  mispredict count (see Optional Feature).

Behaviour:
- Table storage:
  - 2^BHT_BITS entries of 2-bit counters, held in flops.
  - On rst, every entry = WNT (2'b01) in one cycle.
- IF prediction:
  - predict_takenF = branchF & bht[idxF][1]. Purely combinational, zero latency.
- IF->ID register (fields: pred, idx):
  - rst or flushD: pred=0, idx=0.
  - else stallD: hold.
  - else: pred<=predict_takenF, idx<=idxF.
  - stallF alone does not affect this register; the hazard unit guarantees stallF implies stallD or flushD.
- ID check:
  - predict_takenD = registered pred.
  - mispredictD is combinational from branchD, actual_takenD and pred.
  - Reset value of predict_takenD and mispredictD = 0.
- Training:
  - When branchD & ~stallD & ~rst, bht[idxD] updates at the clock edge.
  - Taken: SNT->WNT->WT->ST, saturates at ST.
  - Not taken: ST->WT->WNT->SNT, saturates at SNT.
  - Exactly one update per branch. A branch held by stallD for N cycles updates only in the cycle it leaves ID.
- Read/write collision:
  - If the IF read index equals the ID write index in the same cycle, the IF read returns the old value (no bypass).
- Aliasing:
  - PCs sharing bits [BHT_BITS+1:2] share a counter. This is accepted and not detected.
- Reset mid-operation:
  - rst overrides stall/flush/update.
  - All outputs are 0 the cycle after rst is sampled.

Optional Feature:
- BP_STATS_EN defined:
  - branch_cnt increments on every training event.
  - mispredict_cnt increments when a training event also has mispredictD=1.
  - Both are 32-bit, wrap modulo 2^32, and clear on rst.
- BP_STATS_EN undefined:
  - Counters not instantiated; both ports tied to 32'b0.

Decomposition:
- defines.vh holds:
  - counter encodings `BP_SNT 2'b00, `BP_WNT 2'b01, `BP_WT 2'b10, `BP_ST 2'b11;
  - default `BP_BHT_BITS.
- One natural sub-module: bp_sat_counter, the pure 2-bit saturating next-state function (inputs cur, taken; output nxt), instantiated once for the write port.

Test Plan:
- Reset, then branchF=1 at pcF=0x100 -> predict_takenF=0 (WNT), branch_cnt=0.
- Branch at 0x100 resolved taken (actual_takenD=1) -> mispredictD=1 that cycle; entry becomes WT; next fetch of 0x100 gives predict_takenF=1.
- Same branch taken 4 more times -> counter saturates at ST. One not-taken -> WT, still predicts taken, mispredictD=1 on that not-taken.
- branchD=1 with stallD high for 3 cycles, then low -> exactly one counter step; with BP_STATS_EN, branch_cnt advances by 1.
- flushD with predicted-taken branch in IF -> predict_takenD=0 next cycle; if that slot later shows branchD=1 with actual_takenD=1, mispredictD=1.
- Alias and collision, BHT_BITS=6: train 0x100 to ST, then fetch 0x200 -> predict_takenF=1. Same-cycle read and write of index 0 -> IF sees the pre-update value.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the IF/ID dynamic branch predictor: 2-bit counter states and table size default.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_state_e;

    localparam int BP_BHT_BITS = 6;

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-side signal bundle of the branch predictor; master = pipeline/hazard logic, slave = predictor.
interface branch_predictor_if #(
    parameter int PC_W = 32
);
    logic            stallF;
    logic            stallD;
    logic            flushD;
    logic [PC_W-1:0] pcF;
    logic            branchF;
    logic            predict_takenF;
    logic            branchD;
    logic            actual_takenD;
    logic            predict_takenD;
    logic            mispredictD;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispredict_cnt;

    modport master (
        output stallF, stallD, flushD, pcF, branchF, branchD, actual_takenD,
        input  predict_takenF, predict_takenD, mispredictD, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  stallF, stallD, flushD, pcF, branchF, branchD, actual_takenD,
        output predict_takenF, predict_takenD, mispredictD, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of one 2-bit saturating direction counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  bp_state_e cur,
    input  logic      taken,
    output bp_state_e nxt
);

    function automatic bp_state_e sat_step(bp_state_e c, logic t);
        if (t) begin
            return (c == BP_ST) ? BP_ST : bp_state_e'(c + 2'd1);
        end
        return (c == BP_SNT) ? BP_SNT : bp_state_e'(c - 2'd1);
    endfunction

    assign nxt = sat_step(cur, taken);

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: predicts in IF from a PC-indexed counter table, checks and trains in ID.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_BITS = BP_BHT_BITS,
    parameter int PC_W     = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bus
);

    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0]          bht [ENTRIES];
    logic [BHT_BITS-1:0] idx_f;
    logic [BHT_BITS-1:0] idx_p1;
    logic                pred_p1;
    logic                train;
    bp_state_e           nxt;
    logic                unused_bits;

    // stallF never affects this block; upper/lower PC bits are outside the index
    assign unused_bits = ^{bus.stallF, bus.pcF[PC_W-1:BHT_BITS+2], bus.pcF[1:0]};

    // IF stage: combinational lookup, no bypass from the same-cycle write
    assign idx_f              = bus.pcF[BHT_BITS+1:2];
    assign bus.predict_takenF = bus.branchF & bht[idx_f][1];

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (rst || bus.flushD) begin
            pred_p1 <= 1'b0;
            idx_p1  <= '0;
        end else if (!bus.stallD) begin
            pred_p1 <= bus.predict_takenF;
            idx_p1  <= idx_f;
        end
    end

    // ID stage: check against the resolved direction and train once on exit
    assign bus.predict_takenD = pred_p1;
    assign bus.mispredictD    = bus.branchD & (pred_p1 ^ bus.actual_takenD);
    assign train              = bus.branchD & ~bus.stallD;

    bp_sat_counter u_sat (
        .cur   (bp_state_e'(bht[idx_p1])),
        .taken (bus.actual_takenD),
        .nxt   (nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= BP_WNT;
            end
        end else if (train) begin
            bht[idx_p1] <= nxt;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (train) begin
            branch_cnt_q     <= branch_cnt_q + 32'd1;
            mispredict_cnt_q <= mispredict_cnt_q + {31'd0, bus.mispredictD};
        end
    end

    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
`else
    assign bus.branch_cnt     = 32'd0;
    assign bus.mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed pipeline scenarios plus randomized traffic against a counter-table model.
module tb_branch_predictor;

    localparam int BHT_BITS = 6;
    localparam int PC_W     = 32;
    localparam int ENTRIES  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(PC_W)) bus ();

    branch_predictor #(.BHT_BITS(BHT_BITS), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per-entry counter strength 0..3, the prediction/index carried into ID, and stats
    int          m_cnt [ENTRIES];
    bit          m_pred;
    int          m_idx;
    logic [31:0] m_bc;
    logic [31:0] m_mc;
    bit          checking = 1'b0;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit exp_predF();
        return bus.branchF && (m_cnt[idx_of(bus.pcF)] >= 2);
    endfunction

    function automatic bit exp_mis();
        return bus.branchD && (m_pred != bus.actual_takenD);
    endfunction

    function automatic logic [31:0] stat(logic [31:0] v);
`ifdef BP_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit pf, mis;
        pf  = exp_predF();
        mis = exp_mis();
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) m_cnt[i] = 1;
            m_pred = 1'b0;
            m_idx  = 0;
            m_bc   = '0;
            m_mc   = '0;
        end else begin
            if (bus.branchD && !bus.stallD) begin
                m_bc = m_bc + 1;
                if (mis) m_mc = m_mc + 1;
                if (bus.actual_takenD) m_cnt[m_idx] = (m_cnt[m_idx] < 3) ? m_cnt[m_idx] + 1 : 3;
                else                   m_cnt[m_idx] = (m_cnt[m_idx] > 0) ? m_cnt[m_idx] - 1 : 0;
            end
            if (bus.flushD) begin
                m_pred = 1'b0;
                m_idx  = 0;
            end else if (!bus.stallD) begin
                m_pred = pf;
                m_idx  = idx_of(bus.pcF);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("predict_takenF", {31'd0, bus.predict_takenF}, {31'd0, exp_predF()});
            chk("predict_takenD", {31'd0, bus.predict_takenD}, {31'd0, m_pred});
            chk("mispredictD",    {31'd0, bus.mispredictD},    {31'd0, exp_mis()});
            chk("branch_cnt",     bus.branch_cnt,              stat(m_bc));
            chk("mispredict_cnt", bus.mispredict_cnt,          stat(m_mc));
        end
    end

    task automatic step(bit r, bit sF, bit sD, bit fl, logic [31:0] pc, bit bF, bit bD, bit act);
        @(posedge clk);
        #1;
        rst               = r;
        bus.stallF        = sF;
        bus.stallD        = sD;
        bus.flushD        = fl;
        bus.pcF           = pc;
        bus.branchF       = bF;
        bus.branchD       = bD;
        bus.actual_takenD = act;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        bus.stallF        = 1'b0;
        bus.stallD        = 1'b0;
        bus.flushD        = 1'b0;
        bus.pcF           = '0;
        bus.branchF       = 1'b0;
        bus.branchD       = 1'b0;
        bus.actual_takenD = 1'b0;
        checking          = 1'b1;
        @(posedge clk);

        // Reset state, fetch 0x100 (WNT -> not taken)
        step(0, 0, 0, 0, 32'h100, 1, 0, 0);
        chk("lit_reset_predF", {31'd0, bus.predict_takenF}, 32'd0);
        chk("lit_reset_predD", {31'd0, bus.predict_takenD}, 32'd0);
        chk("lit_reset_misD",  {31'd0, bus.mispredictD},    32'd0);
        chk("lit_reset_bcnt",  bus.branch_cnt,              32'd0);

        // Resolved taken while predicted not taken
        step(0, 0, 0, 0, 32'h104, 0, 1, 1);
        chk("lit_first_mis", {31'd0, bus.mispredictD}, 32'd1);
        step(0, 0, 0, 0, 32'h100, 1, 0, 0);
        chk("lit_wt_predF", {31'd0, bus.predict_takenF}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 32'h100, 1, 1, 1);
            chk("lit_taken_nomis", {31'd0, bus.mispredictD}, 32'd0);
        end
        step(0, 0, 0, 0, 32'h104, 0, 1, 0);
        chk("lit_nt_mis", {31'd0, bus.mispredictD}, 32'd1);
        step(0, 0, 0, 0, 32'h100, 1, 0, 0);
        chk("lit_after_nt_predF", {31'd0, bus.predict_takenF}, 32'd1);

        // Stalled branch at 0x10 trains exactly once
        step(0, 0, 0, 0, 32'h10, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h10, 1, 1, 1);
        step(0, 0, 0, 0, 32'h10, 1, 1, 1);
        step(0, 0, 0, 0, 32'h10, 1, 1, 0);
        chk("lit_stall_collision_predF", {31'd0, bus.predict_takenF}, 32'd1);
        step(0, 0, 0, 0, 32'h10, 1, 0, 0);
        chk("lit_one_step_predF", {31'd0, bus.predict_takenF}, 32'd0);
`ifdef BP_STATS_EN
        chk("lit_bcnt", bus.branch_cnt, 32'd8);
        chk("lit_mcnt", bus.mispredict_cnt, 32'd3);
`else
        chk("lit_bcnt_off", bus.branch_cnt, 32'd0);
        chk("lit_mcnt_off", bus.mispredict_cnt, 32'd0);
`endif

        // Flush a predicted-taken fetch
        step(0, 0, 0, 1, 32'h100, 1, 0, 0);
        chk("lit_flush_predF", {31'd0, bus.predict_takenF}, 32'd1);
        step(0, 0, 0, 0, 32'h200, 1, 1, 1);
        chk("lit_flushed_predD", {31'd0, bus.predict_takenD}, 32'd0);
        chk("lit_flushed_mis",   {31'd0, bus.mispredictD},    32'd1);
        chk("lit_alias_predF",   {31'd0, bus.predict_takenF}, 32'd1);

        // Same-cycle read/write of index 0 returns the old counter
        step(0, 0, 0, 0, 32'h0, 1, 1, 0);
        step(0, 0, 0, 0, 32'h0, 1, 1, 0);
        chk("lit_collision_predF", {31'd0, bus.predict_takenF}, 32'd1);
        step(0, 0, 0, 0, 32'h0, 1, 0, 0);
        chk("lit_post_collision_predF", {31'd0, bus.predict_takenF}, 32'd0);

        // Randomized traffic with heavy aliasing and occasional reset
        for (int i = 0; i < 3000; i++) begin
            bit r, sD, fl, sF;
            r  = ($urandom_range(0, 255) == 0);
            sD = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 9) == 0);
            sF = (sD || fl) ? 1'($urandom_range(0, 1)) : 1'b0;
            step(r, sF, sD, fl, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
